// File: rtl/mood_state_generator_pkg.sv
// Shared types and constants for the mood state generator.
// Event codes, FSM states, level width and accumulator reset points.
package mood_pkg;

  typedef enum logic [2:0] {
    EV_NONE   = 3'd0,
    EV_FEED   = 3'd1,
    EV_PLAY   = 3'd2,
    EV_NOISE  = 3'd3,
    EV_TOUCH  = 3'd4,
    EV_REST   = 3'd5,
    EV_SOOTHE = 3'd6,
    EV_RSVD   = 3'd7
  } ev_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DECAY = 1'b1
  } state_e;

  localparam int LVL_W = 2;

  // Reset points: 1 = mid-scale, 0 = empty
  localparam bit ENERGY_RST_MID   = 1'b1;
  localparam bit STRESS_RST_MID   = 1'b0;
  localparam bit PLEASURE_RST_MID = 1'b1;

  function automatic logic [31:0] acc_rst(
    input int w,
    input bit mid
  );
    logic [31:0] v;
    v = 32'd0;
    if (mid) v = 32'd1 << (w - 1);
    return v;
  endfunction

endpackage

// File: rtl/mood_state_generator_if.sv
// Stimulus event handshake bundle.
// The master holds stim_event stable while stim_valid is high.
interface mood_state_generator_if;

  logic       stim_valid;
  logic       stim_ready;
  logic [2:0] stim_event;

  modport master (
    output stim_valid,
    output stim_event,
    input  stim_ready
  );

  modport slave (
    input  stim_valid,
    input  stim_event,
    output stim_ready
  );

endinterface

// File: rtl/mood_state_generator_sat_accumulator.sv
// Saturating unsigned accumulator with a signed delta input.
// Exposes the register and its top-two-bit quantized level.
module sat_accumulator
  import mood_pkg::*;
#(
  parameter int               ACC_W   = 8,
  parameter logic [ACC_W-1:0] RST_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_en,
  input  logic signed [ACC_W+1:0] i_delta,
  output logic [ACC_W-1:0]        o_acc,
  output logic [LVL_W-1:0]        o_level
);

  logic [ACC_W-1:0]        r_acc;
  logic signed [ACC_W+1:0] w_sum;
  logic [ACC_W-1:0]        w_sat;

  assign w_sum = $signed({2'b00, r_acc}) + i_delta;

  // Clamp the widened sum into [0, 2^ACC_W-1]
  always_comb begin
    w_sat = w_sum[ACC_W-1:0];
    if (w_sum[ACC_W+1]) begin
      w_sat = '0;
    end else if (w_sum[ACC_W]) begin
      w_sat = '1;
    end
  end

  // Accumulator register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= RST_VAL;
    end else if (i_en) begin
      r_acc <= w_sat;
    end
  end

  assign o_acc   = r_acc;
  assign o_level = r_acc[ACC_W-1 -: LVL_W];

endmodule

// File: rtl/mood_state_generator.sv
// Stimulus-driven energy/stress/pleasure level producer.
// Integrates events, decays periodically, registers 2-bit levels.
module mood_state_generator
  import mood_pkg::*;
#(
  parameter int ACC_W     = 8,
  parameter int STEP      = 16,
  parameter int DECAY_DIV = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_tick,
  mood_state_generator_if.slave stim,
  output logic [LVL_W-1:0]   o_energy,
  output logic [LVL_W-1:0]   o_stress,
  output logic [LVL_W-1:0]   o_pleasure,
  output logic               o_level_changed
);

  localparam int SW    = ACC_W + 2;
  localparam int CNT_W = $clog2(DECAY_DIV);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECAY_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [ACC_W-1:0] ENERGY_RST =
    ACC_W'(acc_rst(ACC_W, ENERGY_RST_MID));
  localparam logic [ACC_W-1:0] STRESS_RST =
    ACC_W'(acc_rst(ACC_W, STRESS_RST_MID));
  localparam logic [ACC_W-1:0] PLEASURE_RST =
    ACC_W'(acc_rst(ACC_W, PLEASURE_RST_MID));
  localparam logic [ACC_W-1:0] P_MID =
    ACC_W'(acc_rst(ACC_W, 1'b1));

  localparam logic signed [SW-1:0] D_ONE  = SW'(1);
  localparam logic signed [SW-1:0] D_STEP = SW'(STEP);
  localparam logic signed [SW-1:0] D_HALF = SW'(STEP / 2);
  localparam logic signed [SW-1:0] D_TWO  = SW'(2 * STEP);

  state_e           r_state;
  state_e           w_state_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             r_ready;
  logic             w_ready_nx;
  logic             w_last;

  logic             w_accept;
  logic             w_decay;
  logic             w_upd;
  logic signed [SW-1:0] w_de;
  logic signed [SW-1:0] w_ds;
  logic signed [SW-1:0] w_dp;

  logic [ACC_W-1:0] w_eacc;
  logic [ACC_W-1:0] w_sacc;
  logic [ACC_W-1:0] w_pacc;
  logic [LVL_W-1:0] w_elvl;
  logic [LVL_W-1:0] w_slvl;
  logic [LVL_W-1:0] w_plvl;

  logic [LVL_W-1:0] r_energy;
  logic [LVL_W-1:0] r_stress;
  logic [LVL_W-1:0] r_pleasure;
  logic             r_changed;

  assign w_accept = stim.stim_valid & r_ready;
  assign w_decay  = (r_state == ST_DECAY);
  assign w_upd    = w_accept | w_decay;
  assign w_last   = (r_cnt == CNT_LAST);

  assign stim.stim_ready = r_ready;

  // FSM and tick counter state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_ready <= w_ready_nx;
    end
  end

  // Next state: wrap only from IDLE, a wrap seen in DECAY is held
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (i_tick) begin
          if (w_last) begin
            w_cnt_nx   = '0;
            w_state_nx = ST_DECAY;
          end else begin
            w_cnt_nx = r_cnt + CNT_ONE;
          end
        end
      end
      ST_DECAY: begin
        w_state_nx = ST_IDLE;
        if (i_tick && !w_last) begin
          w_cnt_nx = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
    w_ready_nx = (w_state_nx == ST_IDLE);
  end

  // Event decode, or relaxation deltas in the DECAY cycle
  always_comb begin
    w_de = '0;
    w_ds = '0;
    w_dp = '0;
    if (w_accept) begin
      unique case (ev_e'(stim.stim_event))
        EV_FEED: begin
          w_de = D_STEP;
          w_dp = D_HALF;
        end
        EV_PLAY: begin
          w_dp = D_STEP;
          w_de = -D_STEP;
        end
        EV_NOISE: begin
          w_ds = D_STEP;
        end
        EV_TOUCH: begin
          w_ds = D_STEP;
          w_dp = -D_STEP;
        end
        EV_REST: begin
          w_de = D_STEP;
          w_ds = -D_STEP;
        end
        EV_SOOTHE: begin
          w_ds = -D_TWO;
          w_dp = D_HALF;
        end
        EV_NONE, EV_RSVD: begin
        end
        default: begin
        end
      endcase
    end else if (w_decay) begin
      w_de = -D_ONE;
      w_ds = -D_ONE;
      if (w_pacc > P_MID) begin
        w_dp = -D_ONE;
      end else if (w_pacc < P_MID) begin
        w_dp = D_ONE;
      end
    end
  end

  sat_accumulator #(
    .ACC_W   (ACC_W),
    .RST_VAL (ENERGY_RST)
  ) u_energy (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_upd),
    .i_delta (w_de),
    .o_acc   (w_eacc),
    .o_level (w_elvl)
  );

  sat_accumulator #(
    .ACC_W   (ACC_W),
    .RST_VAL (STRESS_RST)
  ) u_stress (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_upd),
    .i_delta (w_ds),
    .o_acc   (w_sacc),
    .o_level (w_slvl)
  );

  sat_accumulator #(
    .ACC_W   (ACC_W),
    .RST_VAL (PLEASURE_RST)
  ) u_pleasure (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_upd),
    .i_delta (w_dp),
    .o_acc   (w_pacc),
    .o_level (w_plvl)
  );

  // Registered levels and a one-cycle change pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_energy   <= ENERGY_RST[ACC_W-1 -: LVL_W];
      r_stress   <= STRESS_RST[ACC_W-1 -: LVL_W];
      r_pleasure <= PLEASURE_RST[ACC_W-1 -: LVL_W];
      r_changed  <= 1'b0;
    end else begin
      r_energy   <= w_elvl;
      r_stress   <= w_slvl;
      r_pleasure <= w_plvl;
      r_changed  <= (w_elvl != r_energy)
                  | (w_slvl != r_stress)
                  | (w_plvl != r_pleasure);
    end
  end

  assign o_energy        = r_energy;
  assign o_stress        = r_stress;
  assign o_pleasure      = r_pleasure;
  assign o_level_changed = r_changed;

endmodule

// File: tb/tb_mood_state_generator.sv
// Bench for mood_state_generator: directed table, corner sequences,
// and random traffic against an integer-level behavioural model.
module tb_mood_state_generator;
  import mood_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [1:0] le, ls, lp;
  logic       lc;

  mood_state_generator_if sif();

  mood_state_generator #(
    .ACC_W     (8),
    .STEP      (16),
    .DECAY_DIV (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_tick          (tick),
    .stim            (sif),
    .o_energy        (le),
    .o_stress        (ls),
    .o_pleasure      (lp),
    .o_level_changed (lc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: accumulators, registered levels, pulse, ready,
  // "decay cycle is next", pending tick count
  int m_e, m_s, m_p;
  int m_le, m_ls, m_lp;
  int m_cnt;
  bit m_lc, m_rdy, m_dec;

  function automatic void chk(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               nm, act, act, exp, exp, $time);
    end
  endfunction

  function automatic int clamp(int x);
    if (x < 0) return 0;
    if (x > 255) return 255;
    return x;
  endfunction

  function automatic void model_step(bit r, bit t, bit v, int ev);
    int ne, ns, np;
    int nle, nls, nlp;
    bit nd;
    if (r) begin
      m_e = 128; m_s = 0; m_p = 128;
      m_le = 2; m_ls = 0; m_lp = 2;
      m_lc = 0; m_rdy = 0; m_dec = 0; m_cnt = 0;
      return;
    end
    nle = m_e / 64;
    nls = m_s / 64;
    nlp = m_p / 64;
    m_lc = (nle != m_le) || (nls != m_ls) || (nlp != m_lp);
    m_le = nle; m_ls = nls; m_lp = nlp;
    ne = m_e; ns = m_s; np = m_p;
    if (v && m_rdy) begin
      case (ev)
        1: begin ne += 16; np += 8; end
        2: begin np += 16; ne -= 16; end
        3: ns += 16;
        4: begin ns += 16; np -= 16; end
        5: begin ne += 16; ns -= 16; end
        6: begin ns -= 32; np += 8; end
        default: ;
      endcase
    end else if (m_dec) begin
      ne -= 1;
      ns -= 1;
      if (np > 128) np -= 1;
      else if (np < 128) np += 1;
    end
    m_e = clamp(ne); m_s = clamp(ns); m_p = clamp(np);
    nd = 0;
    if (t) begin
      if (!m_dec && m_cnt == 15) begin
        m_cnt = 0;
        nd = 1;
      end else if (!(m_dec && m_cnt == 15)) begin
        m_cnt++;
      end
    end
    m_dec = nd;
    m_rdy = !nd;
  endfunction

  task automatic cyc(bit r, bit t, bit v, logic [2:0] ev);
    rst = r;
    tick = t;
    sif.stim_valid = v;
    sif.stim_event = ev;
    @(posedge clk);
    model_step(r, t, v, int'(ev));
    #1;
    chk("m_lvl_e", int'(le), m_le);
    chk("m_lvl_s", int'(ls), m_ls);
    chk("m_lvl_p", int'(lp), m_lp);
    chk("m_chg", int'(lc), int'(m_lc));
    chk("m_rdy", int'(sif.stim_ready), int'(m_rdy));
    chk("m_eacc", int'(dut.u_energy.r_acc), m_e);
    chk("m_sacc", int'(dut.u_stress.r_acc), m_s);
    chk("m_pacc", int'(dut.u_pleasure.r_acc), m_p);
  endtask

  task automatic idle(int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 3'd0);
  endtask

  task automatic ticks(int n);
    repeat (n) cyc(1'b0, 1'b1, 1'b0, 3'd0);
  endtask

  task automatic do_reset();
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 3'd0);
    idle(1);
  endtask

  typedef struct {
    bit         r;
    bit         t;
    bit         v;
    logic [2:0] ev;
    int         rep;
    int         ea, sa, pa;
    int         xle, xls, xlp;
    bit         xlc;
    bit         xrdy;
  } vec_t;

  vec_t tbl[$];

  initial begin
    sif.stim_valid = 1'b0;
    sif.stim_event = 3'd0;

    tbl.push_back('{1, 0, 0, 3'd0, 2, 'h80, 'h00, 'h80, 2, 0, 2, 0, 0});
    tbl.push_back('{0, 0, 0, 3'd0, 1, 'h80, 'h00, 'h80, 2, 0, 2, 0, 1});
    tbl.push_back('{0, 0, 1, 3'd3, 3, 'h80, 'h30, 'h80, 2, 0, 2, 0, 1});
    tbl.push_back('{0, 0, 1, 3'd3, 1, 'h80, 'h40, 'h80, 2, 0, 2, 0, 1});
    tbl.push_back('{0, 0, 0, 3'd0, 1, 'h80, 'h40, 'h80, 2, 1, 2, 1, 1});
    tbl.push_back('{0, 0, 0, 3'd0, 1, 'h80, 'h40, 'h80, 2, 1, 2, 0, 1});
    tbl.push_back('{0, 0, 1, 3'd3, 11, 'h80, 'hF0, 'h80, 2, 3, 2, 0, 1});
    tbl.push_back('{0, 0, 1, 3'd3, 2, 'h80, 'hFF, 'h80, 2, 3, 2, 0, 1});
    tbl.push_back('{1, 0, 1, 3'd3, 2, 'h80, 'h00, 'h80, 2, 0, 2, 0, 0});
    tbl.push_back('{0, 0, 0, 3'd0, 1, 'h80, 'h00, 'h80, 2, 0, 2, 0, 1});
    tbl.push_back('{0, 0, 1, 3'd6, 1, 'h80, 'h00, 'h88, 2, 0, 2, 0, 1});
    tbl.push_back('{0, 0, 0, 3'd0, 2, 'h80, 'h00, 'h88, 2, 0, 2, 0, 1});
    tbl.push_back('{0, 0, 1, 3'd4, 1, 'h80, 'h10, 'h78, 2, 0, 2, 0, 1});
    tbl.push_back('{0, 0, 0, 3'd0, 1, 'h80, 'h10, 'h78, 2, 0, 1, 1, 1});
    tbl.push_back('{0, 0, 1, 3'd5, 1, 'h90, 'h00, 'h78, 2, 0, 1, 0, 1});
    tbl.push_back('{0, 0, 1, 3'd2, 1, 'h80, 'h00, 'h88, 2, 0, 1, 0, 1});
    tbl.push_back('{0, 0, 0, 3'd0, 1, 'h80, 'h00, 'h88, 2, 0, 2, 1, 1});

    for (int i = 0; i < tbl.size(); i++) begin
      repeat (tbl[i].rep) cyc(tbl[i].r, tbl[i].t, tbl[i].v, tbl[i].ev);
      chk($sformatf("tbl%0d_eacc", i), int'(dut.u_energy.r_acc), tbl[i].ea);
      chk($sformatf("tbl%0d_sacc", i), int'(dut.u_stress.r_acc), tbl[i].sa);
      chk($sformatf("tbl%0d_pacc", i), int'(dut.u_pleasure.r_acc), tbl[i].pa);
      chk($sformatf("tbl%0d_le", i), int'(le), tbl[i].xle);
      chk($sformatf("tbl%0d_ls", i), int'(ls), tbl[i].xls);
      chk($sformatf("tbl%0d_lp", i), int'(lp), tbl[i].xlp);
      chk($sformatf("tbl%0d_chg", i), int'(lc), int'(tbl[i].xlc));
      chk($sformatf("tbl%0d_rdy", i), int'(sif.stim_ready), int'(tbl[i].xrdy));
    end

    // decay after 16 ticks
    do_reset();
    repeat (4) cyc(1'b0, 1'b0, 1'b1, 3'd3);
    ticks(15);
    chk("dec_rdy_before", int'(sif.stim_ready), 1);
    ticks(1);
    chk("dec_rdy_low", int'(sif.stim_ready), 0);
    idle(1);
    chk("dec_rdy_back", int'(sif.stim_ready), 1);
    chk("dec_sacc", int'(dut.u_stress.r_acc), 'h3F);
    chk("dec_eacc", int'(dut.u_energy.r_acc), 'h7F);
    chk("dec_pacc", int'(dut.u_pleasure.r_acc), 'h80);
    chk("dec_ls_old", int'(ls), 1);
    idle(1);
    chk("dec_ls", int'(ls), 0);
    chk("dec_le", int'(le), 1);
    chk("dec_lp", int'(lp), 2);
    chk("dec_chg", int'(lc), 1);
    idle(1);
    chk("dec_chg_off", int'(lc), 0);

    // event and wrap in the same cycle, then held PLAY
    do_reset();
    ticks(15);
    cyc(1'b0, 1'b1, 1'b1, 3'd1);
    chk("col_feed_eacc", int'(dut.u_energy.r_acc), 'h90);
    chk("col_rdy_low", int'(sif.stim_ready), 0);
    cyc(1'b0, 1'b0, 1'b1, 3'd2);
    chk("col_decay_eacc", int'(dut.u_energy.r_acc), 'h8F);
    chk("col_decay_pacc", int'(dut.u_pleasure.r_acc), 'h87);
    chk("col_rdy_back", int'(sif.stim_ready), 1);
    cyc(1'b0, 1'b0, 1'b1, 3'd2);
    chk("col_play_eacc", int'(dut.u_energy.r_acc), 'h7F);
    chk("col_play_pacc", int'(dut.u_pleasure.r_acc), 'h97);
    idle(2);

    // reset mid-stream clears the tick counter
    do_reset();
    ticks(10);
    cyc(1'b1, 1'b1, 1'b1, 3'd3);
    chk("rst_sacc", int'(dut.u_stress.r_acc), 0);
    chk("rst_rdy", int'(sif.stim_ready), 0);
    idle(1);
    ticks(15);
    chk("rst_cnt_no_early", int'(sif.stim_ready), 1);
    ticks(1);
    chk("rst_cnt_wrap", int'(sif.stim_ready), 0);
    idle(2);

    // random traffic
    for (int k = 0; k < 4000; k++) begin
      bit r, t, v;
      logic [2:0] ev;
      r = ($urandom_range(0, 299) == 0);
      t = ($urandom_range(0, 2) == 0);
      v = ($urandom_range(0, 3) != 0);
      ev = 3'($urandom_range(0, 7));
      cyc(r, t, v, ev);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mood_state_generator.md
# mood_state_generator

Stimulus-driven producer of the 2-bit `energy`, `stress` and `pleasure` levels consumed by `emotional_model`.
- Accepts one stimulus event per handshake and integrates it into three saturating accumulators.
- Applies a periodic decay/relaxation step.
- Quantizes each accumulator to a registered 2-bit level.
- Sits between the stimulus/sensor decode logic and the emotion classifier.

## Interface
Parameters:
- `ACC_W`, 8, accumulator width; ≥ 4.
- `STEP`, 16, base increment per event; 2*STEP ≤ 2^(ACC_W-1).
- `DECAY_DIV`, 16, `tick` pulses per decay step; ≥ 2.

Ports:
- `clk` in 1: single clock. Reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `tick` in 1: one-cycle decay time-base pulse.
- `stim_valid` in 1: event present.
- `stim_ready` out 1: block can accept an event this cycle.
- `stim_event` in 3: event code.
- `energy` out 2: quantized energy level.
- `stress` out 2: quantized stress level.
- `pleasure` out 2: quantized pleasure level.
- `level_changed` out 1: one-cycle pulse when any level output changes.

## Operation
Event codes, all deltas signed and applied in one cycle:
- 0 NONE: accepted, no effect.
- 1 FEED: energy +STEP, pleasure +STEP/2.
- 2 PLAY: pleasure +STEP, energy −STEP.
- 3 NOISE: stress +STEP.
- 4 TOUCH: stress +STEP, pleasure −STEP.
- 5 REST: energy +STEP, stress −STEP.
- 6 SOOTHE: stress −2*STEP, pleasure +STEP/2.
- 7 reserved: accepted, no effect.

Arithmetic:
- Accumulators are unsigned `ACC_W` bits.
- Sum is computed at `ACC_W+2` bits signed, then saturated to [0, 2^ACC_W−1]. No wrap-around ever.

Quantization:
- level = acc[ACC_W-1:ACC_W-2], i.e. 0x00–0x3F→0, 0x40–0x7F→1, 0x80–0xBF→2, 0xC0–0xFF→3.

FSM states:
- IDLE: `stim_ready`=1.
- DECAY: `stim_ready`=0.

Transitions:
- Tick counter counts `tick` pulses in both states.
- In IDLE, when a `tick` arrives with the counter at DECAY_DIV−1, the counter wraps to 0 and the next state is DECAY.
- DECAY lasts exactly one cycle, then returns to IDLE.

Decay step, applied in the DECAY cycle:
- energy −1, saturating at 0.
- stress −1, saturating at 0.
- pleasure moves 1 toward 2^(ACC_W-1): −1 if above, +1 if below, unchanged if equal.

Edge cases:
- A `tick` arriving while in DECAY is counted. If it would wrap the counter, the wrap is deferred: the counter holds at DECAY_DIV−1 and the wrap fires on the next IDLE tick.
- The event handshake and a counter wrap may occur in the same IDLE cycle. The event is applied in that cycle and the decay in the following cycle; both take effect.

## Timing
- Reset values:
  - Accumulators: energy 0x80, stress 0x00, pleasure 0x80.
  - Outputs: `energy`=2, `stress`=0, `pleasure`=2, `level_changed`=0, `stim_ready`=0.
  - FSM in IDLE, tick counter 0.
- `stim_ready` is registered and goes to 1 on the first cycle after `rst` deasserts.
- Handshake: an event transfers on a rising edge with `stim_valid && stim_ready`.
  - `stim_event` must be stable while `stim_valid` is high.
  - If `stim_valid` is held while `stim_ready` is low, the event is not lost; the producer holds it.
- Latency:
  - An event accepted at edge N updates the accumulators at edge N.
  - Level outputs update at edge N+1.
  - `level_changed` is high for the cycle after edge N+1 only if any level differs.
  - Decay follows the same rule: accumulator update at the DECAY edge, levels one edge later.
- Throughput: one event per cycle, except the single DECAY cycle.
- `rst` asserted mid-operation discards any in-flight event and restores all reset values at that edge.

## Structure
- Package `mood_pkg` holds:
  - the event code enum (`EV_NONE`…`EV_RSVD`),
  - the FSM state enum,
  - the level width constant (2),
  - reset accumulator constants.
- Sub-module `sat_accumulator` (params `ACC_W`, `RST_VAL`):
  - inputs: signed delta, add enable;
  - output: saturated register plus its 2-bit quantized level;
  - instantiated three times.
- Top level contains the event decoder, tick counter, FSM and output/change registers.

## Test plan
Default parameters throughout.
1. Reset release: outputs 2/0/2 and `level_changed`=0. `stim_ready` is 0 during reset and 1 on the first cycle after.
2. Back-to-back NOISE ×4:
   - stress acc 0x40; `stress`=1 one edge after the 4th accept, with a single `level_changed` pulse.
   - NOISE ×12 more: acc saturates at 0xFF, `stress`=3, no wrap.
3. SOOTHE from reset: stress stays 0x00, `stress`=0, pleasure 0x88, no `level_changed`.
4. Decay:
   - Setup: NOISE ×4 (stress 0x40), then 16 `tick` pulses.
   - After the 16th tick: `stim_ready` is low exactly one cycle and stress acc becomes 0x3F.
   - `stress` 1→0 one edge later, with a `level_changed` pulse.
   - Energy 0x80→0x7F, so `energy` 2→1.
   - Pleasure stays 0x80.
5. Collision:
   - FEED accepted in the same cycle as the 16th tick: energy is 0x90, then decays to 0x8F next cycle.
   - A PLAY held valid during the DECAY cycle is accepted in the following cycle.
6. Reset mid-stream: assert `rst` while `stim_valid` is high. All reset values are restored, no event is applied, and the tick counter restarts from 0.
